// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_pkg
//  Purpose  : Shared constants and state encoding for the IF/ID hazard
//             controller.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  // Opcode carried by a bubble (flushed) instruction in IF/ID
  localparam logic [5:0]  BUBBLE_OP   = 6'b111111;
  // Full instruction word IF/ID loads on a flush
  localparam logic [31:0] BUBBLE_INST = 32'hFC00_0000;

  // Controller state: normal flow, memory freeze, deferred redirect issue
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FREEZE   = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_detect
//  Purpose  : Combinational load-use compare between the load in EX and the
//             source registers of the instruction in ID.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [5:0] id_op_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rt_i,
  output logic       load_use_o
);

  // Register 0 never carries a dependency and a bubble in ID reads nothing;
  // rt only matters when the ID instruction actually sources it.
  assign load_use_o = ex_memread_i
                    && (ex_rt_i != 5'd0)
                    && (id_op_i != BUBBLE_OP)
                    && ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Sequences the IF/ID register and PC: hold, flush, PC write,
//             PC redirect and ID/EX bubble from load-use, taken branch/jump
//             and data-memory-busy events. Redirects seen during a memory
//             freeze are deferred and issued once the freeze ends.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [5:0]        id_op_i,
  input  logic [4:0]        id_rs_i,
  input  logic [4:0]        id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              ex_memread_i,
  input  logic [4:0]        ex_rt_i,
  input  logic              redirect_i,
  input  logic [31:0]       target_i,
  input  logic              mem_busy_i,
  output logic              pc_write_o,
  output logic              ifid_hold_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              pc_redirect_o,
  output logic [31:0]       pc_target_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              timeout_o
);

  // Wide enough to hold MAX_WAIT so the saturated value still trips timeout
  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e             state_q, state_d;
  logic               pend_q, pend_d;
  logic [31:0]        tgt_q, tgt_d;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic               timeout_q;

  logic               w_load_use;
  logic               w_hold;
  logic               w_flush;
  logic               w_bubble;
  logic               w_pc_write;
  logic               w_redirect;
  logic [31:0]        w_target;

  hazard_detect u_hazard_detect (
    .id_op_i      (id_op_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_uses_rt_i (id_uses_rt_i),
    .ex_memread_i (ex_memread_i),
    .ex_rt_i      (ex_rt_i),
    .load_use_o   (w_load_use)
  );

  // Same-cycle control decode and next-state/pending-redirect selection
  always_comb begin
    w_hold     = 1'b0;
    w_flush    = 1'b0;
    w_bubble   = 1'b0;
    w_pc_write = 1'b0;
    w_redirect = 1'b0;
    w_target   = 32'd0;
    state_d    = state_q;
    pend_d     = pend_q;
    tgt_d      = tgt_q;
    case (state_q)
      // RUN and FREEZE share rules: any busy cycle freezes, and the cycle
      // in which busy drops is decoded with the normal-flow priorities.
      ST_RUN, ST_FREEZE: begin
        if (mem_busy_i) begin
          w_hold  = 1'b1;
          state_d = ST_FREEZE;
          // Oldest redirect wins; later ones come from the wrong path
          if (redirect_i && !pend_q) begin
            pend_d = 1'b1;
            tgt_d  = target_i;
          end
        end else begin
          state_d = (state_q == ST_FREEZE && pend_q) ? ST_REDIRECT : ST_RUN;
          // A pending redirect is older than anything decoded now
          if (redirect_i && !pend_q) begin
            w_flush    = 1'b1;
            w_redirect = 1'b1;
            w_target   = target_i;
            w_pc_write = 1'b1;
          end else if (w_load_use) begin
            w_hold   = 1'b1;
            w_bubble = 1'b1;
          end else begin
            w_pc_write = 1'b1;
          end
        end
      end
      ST_REDIRECT: begin
        if (mem_busy_i) begin
          w_hold  = 1'b1;
          state_d = ST_FREEZE;
        end else begin
          w_flush    = 1'b1;
          w_redirect = 1'b1;
          w_target   = tgt_q;
          w_pc_write = 1'b1;
          pend_d     = 1'b0;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        pend_d  = 1'b0;
      end
    endcase
  end

  // State, pending redirect, freeze length, hold statistics and timeout flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      pend_q      <= 1'b0;
      tgt_q       <= 32'd0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      // Timeout latches at the end of the MAX_WAIT-th consecutive busy cycle
      if (mem_busy_i) begin
        if (wait_cnt_q != '1) begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        end
        if (wait_cnt_q >= WAIT_LAST) begin
          timeout_q <= 1'b1;
        end
      end else begin
        wait_cnt_q <= '0;
      end
      if (w_hold && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // Reset forces every control line quiet even though RUN would enable PC
  assign pc_write_o    = w_pc_write & ~rst_i;
  assign ifid_hold_o   = w_hold     & ~rst_i;
  assign ifid_flush_o  = w_flush    & ~rst_i;
  assign idex_bubble_o = w_bubble   & ~rst_i;
  assign pc_redirect_o = w_redirect & ~rst_i;
  assign pc_target_o   = rst_i ? 32'd0 : w_target;
  assign stall_cnt_o   = stall_cnt_q;
  assign timeout_o     = timeout_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [5:0]        id_op_i;
  logic [4:0]        id_rs_i;
  logic [4:0]        id_rt_i;
  logic              id_uses_rt_i;
  logic              ex_memread_i;
  logic [4:0]        ex_rt_i;
  logic              redirect_i;
  logic [31:0]       target_i;
  logic              mem_busy_i;
  logic              pc_write_o;
  logic              ifid_hold_o;
  logic              ifid_flush_o;
  logic              idex_bubble_o;
  logic              pc_redirect_o;
  logic [31:0]       pc_target_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic              timeout_o;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_hazard_ctrl #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_op_i       (id_op_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_uses_rt_i  (id_uses_rt_i),
    .ex_memread_i  (ex_memread_i),
    .ex_rt_i       (ex_rt_i),
    .redirect_i    (redirect_i),
    .target_i      (target_i),
    .mem_busy_i    (mem_busy_i),
    .pc_write_o    (pc_write_o),
    .ifid_hold_o   (ifid_hold_o),
    .ifid_flush_o  (ifid_flush_o),
    .idex_bubble_o (idex_bubble_o),
    .pc_redirect_o (pc_redirect_o),
    .pc_target_o   (pc_target_o),
    .stall_cnt_o   (stall_cnt_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Advance to just after the next rising edge, where inputs are changed
  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Drive all stimulus inputs back to an idle, hazard-free pattern
  task automatic idle_inputs();
    id_op_i = 6'h00; id_rs_i = 5'd0; id_rt_i = 5'd0; id_uses_rt_i = 1'b0;
    ex_memread_i = 1'b0; ex_rt_i = 5'd0;
    redirect_i = 1'b0; target_i = 32'd0; mem_busy_i = 1'b0;
  endtask

  // Check the five single-bit control outputs as a packed vector
  // {pc_write, hold, flush, bubble, redirect}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_write_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, pc_redirect_o},
        {27'd0, exp});
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    // Redirect during reset must not leak out
    redirect_i = 1'b1; target_i = 32'h40; mem_busy_i = 1'b0;
    #2;
    chk_ctl("rst_ctl", 5'b00000);
    chk("rst_target", pc_target_o, 32'd0);
    chk("rst_stall", {28'd0, stall_cnt_o}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
    next_cyc();
    next_cyc();
    rst_i = 1'b0;
    idle_inputs();
    #1;
    chk_ctl("idle_ctl", 5'b10000);

    // Load-use via rs
    next_cyc();
    ex_memread_i = 1'b1; ex_rt_i = 5'd8; id_rs_i = 5'd8; id_op_i = 6'h23;
    #1;
    chk_ctl("lu_rs_ctl", 5'b01010);
    next_cyc();
    ex_memread_i = 1'b0;
    #1;
    chk_ctl("lu_after_ctl", 5'b10000);
    chk("lu_stall", {28'd0, stall_cnt_o}, 32'd1);

    // Load-use via rt only when rt is a source
    next_cyc();
    ex_memread_i = 1'b1; ex_rt_i = 5'd9; id_rs_i = 5'd3; id_rt_i = 5'd9; id_uses_rt_i = 1'b0;
    #1;
    chk_ctl("rt_unused_ctl", 5'b10000);
    id_uses_rt_i = 1'b1;
    #1;
    chk_ctl("rt_used_ctl", 5'b01010);
    next_cyc();
    idle_inputs();

    // No hazard for r0 or a bubble in ID
    ex_memread_i = 1'b1; ex_rt_i = 5'd0; id_rs_i = 5'd0;
    #1;
    chk_ctl("r0_ctl", 5'b10000);
    ex_rt_i = 5'd8; id_rs_i = 5'd8; id_op_i = 6'h3F;
    #1;
    chk_ctl("bubble_op_ctl", 5'b10000);

    // Redirect wins over load-use
    id_op_i = 6'h04; redirect_i = 1'b1; target_i = 32'h40;
    #1;
    chk_ctl("redir_lu_ctl", 5'b10101);
    chk("redir_lu_target", pc_target_o, 32'h40);
    next_cyc();
    idle_inputs();
    #1;
    chk("pre_freeze_stall", {28'd0, stall_cnt_o}, 32'd2);

    // Freeze 3 cycles, redirects in busy cycles 2 and 3; oldest wins
    next_cyc();
    mem_busy_i = 1'b1;
    #1;
    chk_ctl("frz_c1_ctl", 5'b01000);
    next_cyc();
    redirect_i = 1'b1; target_i = 32'h80;
    #1;
    chk_ctl("frz_c2_ctl", 5'b01000);
    next_cyc();
    target_i = 32'hC0;
    #1;
    chk_ctl("frz_c3_ctl", 5'b01000);
    next_cyc();
    idle_inputs();
    #1;
    chk_ctl("frz_exit_ctl", 5'b10000);
    next_cyc();
    #1;
    chk_ctl("frz_redir_ctl", 5'b10101);
    chk("frz_redir_target", pc_target_o, 32'h80);
    next_cyc();
    #1;
    chk_ctl("frz_run_ctl", 5'b10000);
    chk("frz_stall", {28'd0, stall_cnt_o}, 32'd5);

    // Busy again during the REDIRECT cycle: issue is held off, target kept
    mem_busy_i = 1'b1; redirect_i = 1'b1; target_i = 32'h100;
    #1;
    chk_ctl("rb_c1_ctl", 5'b01000);
    next_cyc();
    idle_inputs();
    #1;
    chk_ctl("rb_exit1_ctl", 5'b10000);
    next_cyc();
    mem_busy_i = 1'b1;
    #1;
    chk_ctl("rb_busy_ctl", 5'b01000);
    next_cyc();
    mem_busy_i = 1'b0;
    #1;
    chk_ctl("rb_exit2_ctl", 5'b10000);
    next_cyc();
    #1;
    chk_ctl("rb_redir_ctl", 5'b10101);
    chk("rb_redir_target", pc_target_o, 32'h100);
    chk("rb_timeout", {31'd0, timeout_o}, 32'd0);

    // Six busy cycles with MAX_WAIT=4: timeout visible after busy cycle 4
    for (int i = 1; i <= 6; i++) begin
      next_cyc();
      mem_busy_i = 1'b1;
      #1;
      if (i == 4) chk("to_c4", {31'd0, timeout_o}, 32'd0);
      if (i == 5) chk("to_c5", {31'd0, timeout_o}, 32'd1);
    end
    chk("to_stall", {28'd0, stall_cnt_o}, 32'd12);
    next_cyc();
    mem_busy_i = 1'b0;
    #1;
    chk("to_exit_sticky", {31'd0, timeout_o}, 32'd1);
    next_cyc();
    #1;
    chk("to_run_sticky", {31'd0, timeout_o}, 32'd1);

    // Saturate the 4-bit stall counter: 13 + 3 holds clamps at 15
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      mem_busy_i = 1'b1;
    end
    next_cyc();
    mem_busy_i = 1'b0;
    #1;
    chk("stall_sat", {28'd0, stall_cnt_o}, 32'd15);

    // Async reset in FREEZE with a pending redirect
    next_cyc();
    mem_busy_i = 1'b1; redirect_i = 1'b1; target_i = 32'h200;
    next_cyc();
    redirect_i = 1'b0;
    #1;
    chk_ctl("pr_frz_ctl", 5'b01000);
    rst_i = 1'b1;
    #1;
    chk_ctl("ar_ctl", 5'b00000);
    chk("ar_target", pc_target_o, 32'd0);
    chk("ar_stall", {28'd0, stall_cnt_o}, 32'd0);
    chk("ar_timeout", {31'd0, timeout_o}, 32'd0);
    next_cyc();
    rst_i = 1'b0;
    idle_inputs();
    #1;
    chk_ctl("ar_rel_ctl", 5'b10000);
    next_cyc();
    #1;
    chk_ctl("ar_no_redir_ctl", 5'b10000);
    chk("ar_rel_stall", {28'd0, stall_cnt_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
